// File: rtl/vend_pkg.sv
// Shared types and default timing/stock constants for the vend dispense controller.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMotor,
    StChange
  } vend_state_e;

  localparam int unsigned DispCyclesDef = 8;
  localparam int unsigned ChgCyclesDef  = 4;
  localparam int unsigned StockMaxDef   = 15;

endpackage

// File: rtl/vend_req_fifo.sv
// Small 1-bit-wide request queue; a push while full is discarded even if a pop coincides.
module vend_req_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(Depth);

  logic [Depth-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend dispense controller: queues vend requests, runs the motor, then the change chute or refund.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DISP_CYCLES = DispCyclesDef,
  parameter int unsigned CHG_CYCLES  = ChgCyclesDef,
  parameter int unsigned STOCK_MAX   = StockMaxDef,
  parameter int unsigned PEND_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coke_out,
  input  logic       ret,
  input  logic       refill,
  output logic       motor_on,
  output logic       change_on,
  output logic       refund,
  output logic       sold_out,
  output logic [3:0] stock,
  output logic       busy,
  output logic       drop_err
);

  localparam logic [7:0] DispLoad  = 8'(DISP_CYCLES - 1);
  localparam logic [7:0] ChgLoad   = 8'(CHG_CYCLES - 1);
  localparam logic [3:0] StockLoad = 4'(STOCK_MAX);

  vend_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  stock_q, stock_d;
  logic        ret_q, ret_d;
  logic        refund_q, refund_d;
  logic        armed_q;
  logic        push, pop;
  logic        fifo_rdata, fifo_full, fifo_empty;

  logic       motor_on_q, change_on_q, refund_out_q, sold_out_q, busy_q, drop_err_q;
  logic [3:0] stock_out_q;

  // armed_q masks the first edge after reset release so a held coke_out is not latched.
  assign push = coke_out && armed_q;
  assign pop  = (state_q == StIdle) && !refill && !fifo_empty;

  vend_req_fifo #(
    .Depth (PEND_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (ret),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stock_d  = stock_q;
    ret_d    = ret_q;
    refund_d = refund_q;
    unique case (state_q)
      StIdle: begin
        if (refill) begin
          stock_d = StockLoad;
        end else if (!fifo_empty) begin
          ret_d = fifo_rdata;
          if (stock_q != '0) begin
            stock_d = stock_q - 1'b1;
            state_d = StMotor;
            cnt_d   = DispLoad;
          end else begin
            state_d  = StChange;
            cnt_d    = ChgLoad;
            refund_d = 1'b1;
          end
        end
      end
      StMotor: begin
        if (cnt_q == '0) begin
          if (ret_q) begin
            state_d  = StChange;
            cnt_d    = ChgLoad;
            refund_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StChange: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          refund_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stock_q  <= '0;
      ret_q    <= 1'b0;
      refund_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stock_q  <= stock_d;
      ret_q    <= ret_d;
      refund_q <= refund_d;
      armed_q  <= 1'b1;
    end
  end

  // Output stage mirrors the current state one cycle later, keeping every output a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_on_q   <= 1'b0;
      change_on_q  <= 1'b0;
      refund_out_q <= 1'b0;
      sold_out_q   <= 1'b1;
      stock_out_q  <= '0;
      busy_q       <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      motor_on_q   <= (state_q == StMotor);
      change_on_q  <= (state_q == StChange);
      refund_out_q <= (state_q == StChange) && refund_q;
      sold_out_q   <= (stock_q == '0);
      stock_out_q  <= stock_q;
      busy_q       <= (state_q != StIdle) || !fifo_empty;
      drop_err_q   <= push && fifo_full;
    end
  end

  assign motor_on  = motor_on_q;
  assign change_on = change_on_q;
  assign refund    = refund_out_q;
  assign sold_out  = sold_out_q;
  assign stock     = stock_out_q;
  assign busy      = busy_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with hand-computed expectations.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, coke_out, ret, refill;
  logic       motor_on, change_on, refund, sold_out, busy, drop_err;
  logic [3:0] stock;

  int n_checks = 0;
  int n_fail   = 0;
  int rises, drops, min_gap, low_run, both_cnt;
  logic prev_motor;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coke_out  (coke_out),
    .ret       (ret),
    .refill    (refill),
    .motor_on  (motor_on),
    .change_on (change_on),
    .refund    (refund),
    .sold_out  (sold_out),
    .stock     (stock),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    rises      = 0;
    drops      = 0;
    min_gap    = 1000;
    low_run    = 0;
    prev_motor = motor_on;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (motor_on && change_on) both_cnt++;
    if (drop_err) drops++;
    if (motor_on && !prev_motor) begin
      if (rises > 0 && low_run < min_gap) min_gap = low_run;
      rises++;
    end
    low_run    = motor_on ? 0 : low_run + 1;
    prev_motor = motor_on;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_refill();
    refill = 1'b1;
    step();
    refill = 1'b0;
  endtask

  task automatic vend(input logic r);
    coke_out = 1'b1;
    ret      = r;
    step();
    coke_out = 1'b0;
    ret      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(2);
  endtask

  initial begin
    both_cnt = 0;
    rst_n    = 1'b0;
    coke_out = 1'b0;
    ret      = 1'b0;
    refill   = 1'b0;
    mon_clear();
    steps(2);
    check_eq("rst_motor", motor_on, 0);
    check_eq("rst_change", change_on, 0);
    check_eq("rst_refund", refund, 0);
    check_eq("rst_drop", drop_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sold_out", sold_out, 1);
    check_eq("rst_stock", stock, 0);

    // coke_out already high at release: first edge must not latch it
    coke_out = 1'b1;
    rst_n    = 1'b1;
    step();
    coke_out = 1'b0;
    step();
    check_eq("no_push_first_edge_busy", busy, 0);
    step();
    check_eq("no_push_first_edge_change", change_on, 0);
    steps(3);

    // Plain vend, ret=0
    do_refill();
    steps(2);
    check_eq("refill_stock", stock, 15);
    check_eq("refill_sold_out", sold_out, 0);
    mon_clear();
    vend(1'b0);
    step();
    check_eq("vend0_lat1", motor_on, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("vend0_motor", motor_on, 1);
      check_eq("vend0_change", change_on, 0);
    end
    step();
    check_eq("vend0_motor_off", motor_on, 0);
    steps(4);
    check_eq("vend0_stock", stock, 14);
    check_eq("vend0_rises", rises, 1);
    check_eq("vend0_busy", busy, 0);

    // Vend with change at stock 15
    do_refill();
    steps(2);
    vend(1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("vend1_motor", motor_on, 1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("vend1_change", change_on, 1);
      check_eq("vend1_motor_low", motor_on, 0);
      check_eq("vend1_refund", refund, 0);
      check_eq("vend1_busy_hi", busy, 1);
    end
    step();
    check_eq("vend1_change_off", change_on, 0);
    check_eq("vend1_busy_fall", busy, 0);
    check_eq("vend1_stock", stock, 14);

    // Sold-out request takes the refund path
    do_reset();
    mon_clear();
    vend(1'b0);
    step();
    check_eq("refund_lat1", change_on, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("refund_change", change_on, 1);
      check_eq("refund_flag", refund, 1);
    end
    step();
    check_eq("refund_change_off", change_on, 0);
    check_eq("refund_flag_off", refund, 0);
    steps(3);
    check_eq("refund_no_motor", rises, 0);
    check_eq("refund_stock", stock, 0);
    check_eq("refund_sold_out", sold_out, 1);

    // Six requests while the motor runs: four queue, two drop
    do_refill();
    steps(2);
    mon_clear();
    vend(1'b0);
    step();
    coke_out = 1'b1;
    steps(6);
    coke_out = 1'b0;
    steps(70);
    check_eq("burst_drops", drops, 2);
    check_eq("burst_vends", rises, 5);
    check_eq("burst_gap", min_gap, 1);
    check_eq("burst_stock", stock, 10);
    check_eq("burst_busy", busy, 0);

    // Reset in the middle of MOTOR with a request queued
    do_refill();
    steps(2);
    vend(1'b0);
    step();
    vend(1'b0);
    steps(3);
    check_eq("midrst_motor_before", motor_on, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_motor_async", motor_on, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_stock", stock, 0);
    steps(2);
    rst_n = 1'b1;
    mon_clear();
    steps(30);
    check_eq("midrst_no_vend", rises, 0);
    check_eq("midrst_no_change", change_on, 0);
    check_eq("midrst_busy_after", busy, 0);
    check_eq("midrst_sold_out", sold_out, 1);

    // Refill coinciding with a pending pop in IDLE
    vend(1'b0);
    refill = 1'b1;
    step();
    refill = 1'b0;
    check_eq("refpop_stock_e1", stock, 0);
    step();
    check_eq("refpop_stock_e2", stock, 15);
    check_eq("refpop_motor_e2", motor_on, 0);
    step();
    check_eq("refpop_stock_e3", stock, 14);
    check_eq("refpop_motor_e3", motor_on, 1);
    steps(12);

    check_eq("never_both", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter DISP_CYCLES, default 8: motor-on duration per vend, in clk cycles (range 1..255).
REQ-002 Parameter CHG_CYCLES, default 4: change-chute duration per change or refund, in clk cycles (range 1..255).
REQ-003 Parameter STOCK_MAX, default 15: stock value loaded on refill; the stock counter is 4 bits.
REQ-004 Parameter PEND_DEPTH, default 4: number of pending vend requests the block can hold.
REQ-005 clk  input  1  system clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 coke_out  input  1  one-cycle vend request from the upstream coin FSM.
REQ-008 ret  input  1  change-due flag; qualified only in a cycle where coke_out=1.
REQ-009 refill  input  1  operator refill strobe.
REQ-010 motor_on  output  1  dispense motor drive.
REQ-011 change_on  output  1  change-chute drive.
REQ-012 refund  output  1  high with change_on when a paid request found stock empty.
REQ-013 sold_out  output  1  high when stock==0.
REQ-014 stock  output  4  current can count.
REQ-015 busy  output  1  high when state!=IDLE or the pending queue is non-empty.
REQ-016 drop_err  output  1  one-cycle pulse when a request is lost because the queue is full.

Function
REQ-017 Push {ret} into the pending queue on every clk edge where coke_out=1; ignore ret when coke_out=0.
REQ-018 A push when the queue is full is discarded and drop_err pulses the next cycle, even if a pop happens in the same cycle.
REQ-019 The FSM has exactly three states: IDLE, MOTOR, CHANGE.
REQ-020 In IDLE, with the queue non-empty and refill=0, pop one entry: if stock>0, decrement stock and go to MOTOR; if stock==0, go to CHANGE with refund set.
REQ-021 In IDLE, refill=1 loads stock=STOCK_MAX and defers any pop by one cycle; refill in MOTOR or CHANGE is ignored.
REQ-022 MOTOR holds motor_on=1 for exactly DISP_CYCLES cycles, then goes to CHANGE if the popped ret=1, otherwise to IDLE.
REQ-023 CHANGE holds change_on=1 (plus refund if set) for exactly CHG_CYCLES cycles, then goes to IDLE and clears refund.
REQ-024 Every exit to IDLE spends at least one cycle in IDLE before the next pop; motor_on and change_on are never both high.
REQ-025 All outputs are registered; motor_on rises 2 cycles after the coke_out edge when the block is idle and the queue is empty.
REQ-026 Stock never wraps below 0; a pop at stock==0 follows the refund path only.
REQ-027 sold_out and stock update in the cycle after the decrement or refill.

Reset
REQ-028 Asserting rst_n low clears the queue, sets state=IDLE, stock=0, and drives motor_on=0, change_on=0, refund=0, drop_err=0, busy=0, sold_out=1, regardless of the current state.
REQ-029 No request is latched in the first edge after rst_n deasserts if coke_out is already high; pushes start from the second edge.

Structure
REQ-030 Package vend_pkg holds the state enumeration and the default values of DISP_CYCLES, CHG_CYCLES and STOCK_MAX.
REQ-031 The pending queue is sub-module vend_req_fifo (1-bit wide, PEND_DEPTH deep, with full/empty flags); the FSM and counters stay in the top module.

Verification
REQ-032 Reset, refill, then coke_out with ret=0 -> motor_on high for 8 cycles starting 2 cycles later, change_on never high, stock goes 15->14.
REQ-033 coke_out with ret=1 at stock=15 -> 8 cycles motor_on, then 4 cycles change_on, refund=0, busy falls after the last change cycle.
REQ-034 coke_out at stock=0 -> no motor_on, 4 cycles change_on with refund=1, stock stays 0, sold_out stays 1.
REQ-035 Six coke_out pulses while in MOTOR, depth 4 -> two drop_err pulses, then four queued vends each separated by at least one IDLE cycle.
REQ-036 rst_n low midway through MOTOR -> motor_on drops asynchronously, queue empties, stock=0, and no vend occurs after release.
REQ-037 refill and a pending pop in the same IDLE cycle -> stock=15 first, pop on the next edge, stock reads 14 after that.
